// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: per-channel two-flop synchroniser, press/release
// debouncer, registered clean level, press/release pulses and optional hold-to-repeat pulses.
module btn_conditioner #(
   parameter int N_CH          = 5,
   parameter int DEB_CYCLES    = 500000,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int CNT_W         = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] btn_in,
   input  logic [N_CH-1:0] repeat_en,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_press,
   output logic [N_CH-1:0] btn_release,
   output logic [N_CH-1:0] btn_ccen
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT_P = 3'd1,
      ST_HELD   = 3'd2,
      ST_REPEAT = 3'd3,
      ST_WAIT_R = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CYCLES - 1);

   logic [N_CH-1:0] sync1_r;
   logic [N_CH-1:0] sync2_r;

   // Two-flop synchroniser for the raw asynchronous buttons.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= {N_CH{1'b0}};
         sync2_r <= {N_CH{1'b0}};
      end else begin
         sync1_r <= btn_in;
         sync2_r <= sync1_r;
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_CH; g++) begin : gen_ch
         state_t           state_r, state_s;
         logic [CNT_W-1:0] cnt_r, cnt_s;
         logic             level_r, press_r, release_r, ccen_r;
         logic             level_s, press_s, release_s, ccen_s;
         logic             s_s;

         assign s_s = sync2_r[g];

         // Next-state, counter and pulse decode for one channel.
         always_comb begin
            state_s   = state_r;
            cnt_s     = cnt_r;
            press_s   = 1'b0;
            release_s = 1'b0;
            ccen_s    = 1'b0;
            case (state_r)
               ST_IDLE: begin
                  cnt_s = CNT_ZERO;
                  if (s_s) begin
                     state_s = ST_WAIT_P;
                  end else begin
                     state_s = ST_IDLE;
                  end
               end
               ST_WAIT_P: begin
                  if (!s_s) begin
                     state_s = ST_IDLE;
                     cnt_s   = CNT_ZERO;
                  end else if (cnt_r == DEB_LAST) begin
                     state_s = ST_HELD;
                     cnt_s   = CNT_ZERO;
                     press_s = 1'b1;
                     ccen_s  = 1'b1;
                  end else begin
                     cnt_s = cnt_r + CNT_ONE;
                  end
               end
               ST_HELD: begin
                  if (!s_s) begin
                     state_s = ST_WAIT_R;
                     cnt_s   = CNT_ZERO;
                  end else if (repeat_en[g] && (cnt_r == HOLD_LAST)) begin
                     state_s = ST_REPEAT;
                     cnt_s   = CNT_ZERO;
                     ccen_s  = 1'b1;
                  end else if (repeat_en[g]) begin
                     cnt_s = cnt_r + CNT_ONE;
                  end else begin
                     cnt_s = CNT_ZERO;
                  end
               end
               ST_REPEAT: begin
                  if (!s_s) begin
                     state_s = ST_WAIT_R;
                     cnt_s   = CNT_ZERO;
                  end else if (!repeat_en[g]) begin
                     state_s = ST_HELD;
                     cnt_s   = CNT_ZERO;
                  end else if (cnt_r == REP_LAST) begin
                     cnt_s  = CNT_ZERO;
                     ccen_s = 1'b1;
                  end else begin
                     cnt_s = cnt_r + CNT_ONE;
                  end
               end
               ST_WAIT_R: begin
                  if (s_s) begin
                     // A short low glitch is a bounce: back to HELD and restart hold timing.
                     state_s = ST_HELD;
                     cnt_s   = CNT_ZERO;
                  end else if (cnt_r == DEB_LAST) begin
                     state_s   = ST_IDLE;
                     cnt_s     = CNT_ZERO;
                     release_s = 1'b1;
                  end else begin
                     cnt_s = cnt_r + CNT_ONE;
                  end
               end
               default: begin
                  state_s = ST_IDLE;
                  cnt_s   = CNT_ZERO;
               end
            endcase
            if ((state_s == ST_HELD) || (state_s == ST_REPEAT) || (state_s == ST_WAIT_R)) begin
               level_s = 1'b1;
            end else begin
               level_s = 1'b0;
            end
         end

         // State, counter and registered outputs for one channel.
         always_ff @(posedge clk) begin
            if (reset) begin
               state_r   <= ST_IDLE;
               cnt_r     <= CNT_ZERO;
               level_r   <= 1'b0;
               press_r   <= 1'b0;
               release_r <= 1'b0;
               ccen_r    <= 1'b0;
            end else begin
               state_r   <= state_s;
               cnt_r     <= cnt_s;
               level_r   <= level_s;
               press_r   <= press_s;
               release_r <= release_s;
               ccen_r    <= ccen_s;
            end
         end

         assign btn_level[g]   = level_r;
         assign btn_press[g]   = press_r;
         assign btn_release[g] = release_r;
         assign btn_ccen[g]    = ccen_r;
      end
   endgenerate

endmodule
